// File: rtl/demux2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : demux2_pipe
// Description : Registered 1-to-2 stream demultiplexer. Input words tagged
//               with a select bit are buffered in a 2-entry in-order queue
//               and delivered to destination A (sel=0) or B (sel=1) over
//               independent valid/ready ports. Per-destination transfer
//               counters are provided for debug and performance monitoring.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   bitwidth : data width of the input and both outputs
//   cntwidth : width of each per-destination transfer counter
// Ports:
//   clk      in   1         rising-edge clock
//   rst      in   1         asynchronous active-high reset
//   in_valid in   1         input word present
//   in_ready out  1         queue can accept a word this cycle
//   in_sel   in   1         destination of input word (0 = A, 1 = B)
//   in_data  in   bitwidth  input word
//   a_valid  out  1         head word is for A
//   a_ready  in   1         A accepts
//   a_data   out  bitwidth  head word data
//   b_valid  out  1         head word is for B
//   b_ready  in   1         B accepts
//   b_data   out  bitwidth  head word data
//   level    out  2         queue occupancy, 0..2
//   a_count  out  cntwidth  words delivered to A (wrapping)
//   b_count  out  cntwidth  words delivered to B (wrapping)
// ============================================================================
module demux2_pipe #(
    parameter int bitwidth = 32,
    parameter int cntwidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sel,
    input  logic [bitwidth-1:0] in_data,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [bitwidth-1:0] a_data,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [bitwidth-1:0] b_data,
    output logic [1:0]          level,
    output logic [cntwidth-1:0] a_count,
    output logic [cntwidth-1:0] b_count
);

    localparam logic [1:0] c_FULL = 2'd2;

    // Queue storage and bookkeeping
    logic                r_sel  [0:1];
    logic [bitwidth-1:0] r_data [0:1];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_level;
    logic [cntwidth-1:0] r_a_cnt;
    logic [cntwidth-1:0] r_b_cnt;

    logic                w_not_empty;
    logic                w_head_sel;
    logic                w_a_valid;
    logic                w_b_valid;
    logic                w_in_ready;
    logic                w_push;
    logic                w_pop_a;
    logic                w_pop_b;
    logic                w_pop;

    // All handshake outputs derive from registered state only, so there is
    // no combinational path from any input to any output.
    assign w_not_empty = (r_level != 2'd0);
    assign w_head_sel  = r_sel[r_rptr];
    assign w_a_valid   = w_not_empty && !w_head_sel;
    assign w_b_valid   = w_not_empty &&  w_head_sel;
    assign w_in_ready  = (r_level != c_FULL);

    assign w_push  = in_valid && w_in_ready;
    // Only the destination that owns the head can pop; a ready on the other
    // side is ignored because its valid is low.
    assign w_pop_a = w_a_valid && a_ready;
    assign w_pop_b = w_b_valid && b_ready;
    assign w_pop   = w_pop_a || w_pop_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel[0]  <= 1'b0;
            r_sel[1]  <= 1'b0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_level   <= 2'd0;
            r_a_cnt   <= '0;
            r_b_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_sel[r_wptr]  <= in_sel;
                r_data[r_wptr] <= in_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
            if (w_pop_a) begin
                r_a_cnt <= r_a_cnt + 1'b1;
            end
            if (w_pop_b) begin
                r_b_cnt <= r_b_cnt + 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign a_valid  = w_a_valid;
    assign b_valid  = w_b_valid;
    // Both data ports always show the head entry, qualified by their valid
    assign a_data   = r_data[r_rptr];
    assign b_data   = r_data[r_rptr];
    assign level    = r_level;
    assign a_count  = r_a_cnt;
    assign b_count  = r_b_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux2_pipe
// Description : Self-checking testbench for demux2_pipe with a queue-based
//               reference model (cntwidth = 2 to exercise counter wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux2_pipe;

    localparam int c_BW = 32;
    localparam int c_CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sel = 1'b0;
    logic [c_BW-1:0] in_data = '0;
    logic            a_valid;
    logic            a_ready = 1'b0;
    logic [c_BW-1:0] a_data;
    logic            b_valid;
    logic            b_ready = 1'b0;
    logic [c_BW-1:0] b_data;
    logic [1:0]      level;
    logic [c_CW-1:0] a_count;
    logic [c_CW-1:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: in-order queue of {sel, data} plus delivery counts
    logic [c_BW:0]   mq[$];
    logic [c_CW-1:0] m_a = '0;
    logic [c_CW-1:0] m_b = '0;

    demux2_pipe #(.bitwidth(c_BW), .cntwidth(c_CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .level(level), .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs (called at a negedge), advance the model on
    // the rising edge and return at the following negedge.
    task automatic step(input logic iv, input logic isel, input logic [c_BW-1:0] idata,
                        input logic ar, input logic br);
        logic pop;
        logic push;
        in_valid = iv; in_sel = isel; in_data = idata; a_ready = ar; b_ready = br;
        @(posedge clk);
        pop = 1'b0;
        if (mq.size() > 0) pop = mq[0][c_BW] ? br : ar;
        push = iv && (mq.size() < 2);
        if (pop) begin
            if (mq[0][c_BW]) m_b = m_b + 1'b1;
            else             m_a = m_a + 1'b1;
            void'(mq.pop_front());
        end
        if (push) mq.push_back({isel, idata});
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        mq.delete(); m_a = '0; m_b = '0;
        in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Leave a word buffered, then reset asynchronously mid-cycle
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, a_valid, b_valid, level, a_count, b_count} !== {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b av=%b bv=%b lvl=%0d ac=%0d bc=%0d expected 1 0 0 0 0 0",
                     in_ready, a_valid, b_valid, level, a_count, b_count);
        end
        n_tests++;
        if (a_data !== 32'd0 || b_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h expected 0 0", a_data, b_data);
        end
        mq.delete(); m_a = '0; m_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        n_tests++;
        if (a_valid !== 1'b1 || b_valid !== 1'b0 || a_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_out: got av=%b bv=%b data=%h expected 1 0 deadbeef", a_valid, b_valid, a_data);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        n_tests++;
        if (a_valid !== 1'b0 || level !== 2'd0 || a_count !== 2'd1 || b_count !== 2'd0) begin
            n_fail++;
            $display("FAIL single_after: got av=%b lvl=%0d ac=%0d bc=%0d expected 0 0 1 0",
                     a_valid, level, a_count, b_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [c_BW-1:0] got[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (a_valid) got.push_back(a_data);
            if (b_valid) got.push_back(b_data | 32'h100);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready cycle %0d: got %b expected 1", i, in_ready);
            end
            if (i < 4) step(1'b1, i[0], 32'(i + 1), 1'b1, 1'b1);
            else       step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        end
        n_tests++;
        if (got.size() != 4 || got[0] !== 32'h001 || got[1] !== 32'h102 ||
            got[2] !== 32'h003 || got[3] !== 32'h104) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d words expected 1A 2B 3A 4B in order", got.size());
        end
        n_tests++;
        if (a_count !== 2'd2 || b_count !== 2'd2) begin
            n_fail++;
            $display("FAIL b2b_counts: got a=%0d b=%0d expected 2 2", a_count, b_count);
        end
    endtask

    task automatic test_full_hol();
        do_reset();
        step(1'b1, 1'b0, 32'h10, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b1);
        n_tests++;
        if (level !== 2'd2 || in_ready !== 1'b0 || b_valid !== 1'b0 || a_valid !== 1'b1 || a_data !== 32'h10) begin
            n_fail++;
            $display("FAIL full_state: got lvl=%0d rdy=%b bv=%b av=%b data=%h expected 2 0 0 1 10",
                     level, in_ready, b_valid, a_valid, a_data);
        end
        step(1'b1, 1'b0, 32'h30, 1'b0, 1'b1);
        n_tests++;
        if (level !== 2'd2 || b_valid !== 1'b0 || a_data !== 32'h10) begin
            n_fail++;
            $display("FAIL full_reject: got lvl=%0d bv=%b data=%h expected 2 0 10", level, b_valid, a_data);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== 32'h20 || a_valid !== 1'b0 || in_ready !== 1'b1 || a_count !== 2'd1) begin
            n_fail++;
            $display("FAIL hol_release: got bv=%b data=%h av=%b rdy=%b ac=%0d expected 1 20 0 1 1",
                     b_valid, b_data, a_valid, in_ready, a_count);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        n_tests++;
        if (level !== 2'd0 || b_count !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_drain: got lvl=%0d bc=%0d rdy=%b expected 0 1 1", level, b_count, in_ready);
        end
    endtask

    // Randomised traffic compared every cycle against the queue model
    task automatic test_random(input int cycles, input bit alternate_stall);
        logic            ev_a;
        logic            ev_b;
        logic [c_BW-1:0] ev_d;
        for (int i = 0; i < cycles; i++) begin
            ev_a = (mq.size() > 0) && !mq[0][c_BW];
            ev_b = (mq.size() > 0) &&  mq[0][c_BW];
            ev_d = (mq.size() > 0) ? mq[0][c_BW-1:0] : '0;
            n_tests++;
            if (level !== 2'(mq.size()) || in_ready !== (mq.size() < 2) ||
                a_valid !== ev_a || b_valid !== ev_b ||
                a_count !== m_a || b_count !== m_b) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d: got lvl=%0d rdy=%b av=%b bv=%b ac=%0d bc=%0d expected %0d %b %b %b %0d %0d",
                         i, level, in_ready, a_valid, b_valid, a_count, b_count,
                         mq.size(), (mq.size() < 2), ev_a, ev_b, m_a, m_b);
            end
            if (ev_a || ev_b) begin
                n_tests++;
                if ((ev_a && a_data !== ev_d) || (ev_b && b_data !== ev_d)) begin
                    n_fail++;
                    $display("FAIL rand_data cycle %0d: got a=%h b=%h expected %h", i, a_data, b_data, ev_d);
                end
            end
            if (alternate_stall)
                step(1'b1, i[0], 32'h100 + 32'(i), i[1], ~i[1]);
            else
                step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end
    endtask

    task automatic test_counter_wrap();
        logic [c_CW-1:0] exp_seq [0:4];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        do_reset();
        step(1'b1, 1'b1, 32'hB0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, 1'b1, 32'hB1 + 32'(i), 1'b0, 1'b1);
            else       step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            n_tests++;
            if (b_count !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL bcount_wrap %0d: got %0d expected %0d", i, b_count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        step(1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hBB, 1'b0, 1'b0);
        n_tests++;
        if (level !== 2'd2) begin
            n_fail++;
            $display("FAIL midrst_fill: got lvl=%0d expected 2", level);
        end
        do_reset();
        step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
        n_tests++;
        if (level !== 2'd1 || a_valid !== 1'b1 || a_data !== 32'h77 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_first: got lvl=%0d av=%b data=%h bv=%b expected 1 1 77 0",
                     level, a_valid, a_data, b_valid);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        n_tests++;
        if (level !== 2'd0 || a_count !== 2'd1 || b_count !== 2'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_drain: got lvl=%0d ac=%0d bc=%0d av=%b bv=%b expected 0 1 0 0 0",
                     level, a_count, b_count, a_valid, b_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full_hol();
        do_reset();
        test_random(12, 1'b1);
        test_counter_wrap();
        test_reset_mid_op();
        do_reset();
        test_random(400, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
